// File: rtl/hamming12_pkg.sv
// Shared Hamming(12,8) codeword map used by the encoder and the decoder.
// Provides widths, parity bit indices and the pure encode function.
package hamming12_pkg;

  localparam int CW_W   = 12;
  localparam int DATA_W = 8;

  // Parity bits sit at positions 1,2,4,8 (bit indices 0,1,3,7).
  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 3;
  localparam int P3 = 7;

  function automatic logic [CW_W-1:0] hamming12_encode(
    input logic [DATA_W-1:0] d
  );
    logic [CW_W-1:0] c;
    c       = '0;
    c[11:8] = d[7:4];
    c[6:4]  = d[3:1];
    c[2]    = d[0];
    c[P0]   = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10];
    c[P1]   = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10];
    c[P2]   = c[4] ^ c[5] ^ c[6] ^ c[11];
    c[P3]   = c[8] ^ c[9] ^ c[10] ^ c[11];
    return c;
  endfunction

  // One-hot flip mask for a 1-indexed position; zero outside 1..12.
  function automatic logic [CW_W-1:0] hamming12_flip(
    input logic       en,
    input logic [3:0] pos
  );
    logic [CW_W-1:0] m;
    logic [3:0]      sh;
    m  = '0;
    sh = pos - 4'd1;
    if (en && pos >= 4'd1 && pos <= 4'd12)
      m = {{(CW_W-1){1'b0}}, 1'b1} << sh;
    return m;
  endfunction

endpackage

// File: rtl/hamming12_encoder_tx_fifo.sv
// Synchronous FIFO holding codewords between encoder and downstream.
// Ports: push/wdata in, pop/rdata out, full/empty flags, level count.
module hamming12_encoder_tx_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Storage is never cleared; level alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && do_push)
      mem[wptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap by overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push)
        wptr <= wptr + AW'(1);
      if (do_pop)
        rptr <= rptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/hamming12_encoder_tx.sv
// Hamming(12,8) transmit encoder with fault injection and output FIFO.
// Ports: byte in (valid/ready), codeword out (valid/ready), level, count.
module hamming12_encoder_tx
  import hamming12_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     inj_en,
  input  logic [3:0]               inj_pos,
  output logic [11:0]              cw_data,
  output logic                     cw_valid,
  input  logic                     cw_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         cw_count
);

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [CW_W-1:0] enc;

  assign in_ready = !full;
  assign cw_valid = !empty;
  assign push     = in_valid && in_ready;
  assign pop      = cw_valid && cw_ready;
  assign enc      = hamming12_encode(in_data)
                  ^ hamming12_flip(inj_en, inj_pos);

  hamming12_encoder_tx_fifo #(
    .WIDTH (CW_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (enc),
    .pop   (pop),
    .rdata (cw_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk) begin
    if (rst)
      cw_count <= '0;
    else if (pop)
      cw_count <= cw_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_hamming12_encoder_tx.sv
// Self-checking bench for hamming12_encoder_tx.
// Queue model of the FIFO plus positional Hamming reference encoder.
module tb_hamming12_encoder_tx;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          inj_en;
  logic [3:0]    inj_pos;
  logic [11:0]   cw_data;
  logic          cw_valid;
  logic          cw_ready;
  logic [LW-1:0] level;
  logic [CNT_W-1:0] cw_count;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;
  logic [11:0] q [$];
  int mcnt = 0;

  always #5 clk = ~clk;

  hamming12_encoder_tx #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .inj_en   (inj_en),
    .inj_pos  (inj_pos),
    .cw_data  (cw_data),
    .cw_valid (cw_valid),
    .cw_ready (cw_ready),
    .level    (level),
    .cw_count (cw_count)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: place data bits at non-power-of-two positions,
  // then each parity position p covers positions with bit p set.
  function automatic logic [11:0] model_cw(input logic [7:0] d,
                                           input logic en,
                                           input logic [3:0] pos);
    logic [12:1] p;
    int k;
    p = '0;
    k = 0;
    for (int i = 1; i <= 12; i++)
      if ((i & (i - 1)) != 0) begin
        p[i] = d[k];
        k++;
      end
    for (int b = 0; b < 4; b++) begin
      logic par;
      par = 1'b0;
      for (int i = 1; i <= 12; i++)
        if (((i >> b) & 1) == 1) par ^= p[i];
      p[1 << b] = par;
    end
    if (en && pos >= 1 && pos <= 12) p[pos] = ~p[pos];
    return p;
  endfunction

  function automatic logic [7:0] decode(input logic [11:0] cw);
    logic [12:1] p;
    int syn;
    int k;
    logic [7:0] d;
    p = cw;
    syn = 0;
    for (int i = 1; i <= 12; i++)
      if (p[i]) syn ^= i;
    if (syn >= 1 && syn <= 12) p[syn] = ~p[syn];
    k = 0;
    d = '0;
    for (int i = 1; i <= 12; i++)
      if ((i & (i - 1)) != 0) begin
        d[k] = p[i];
        k++;
      end
    return d;
  endfunction

  // Compare then advance the model; inputs only change at posedge+1.
  initial begin
    forever begin
      @(negedge clk);
      if (model_on) begin
        chk("in_ready", in_ready, (q.size() < DEPTH));
        chk("cw_valid", cw_valid, (q.size() != 0));
        chk("level", level, q.size());
        chk("cw_count", cw_count, mcnt);
        if (q.size() != 0) chk("cw_data", cw_data, q[0]);
      end
      if (rst) begin
        q.delete();
        mcnt = 0;
        model_on = 1'b1;
      end else if (model_on) begin
        bit pop_m;
        bit push_m;
        logic [11:0] nw;
        pop_m  = (q.size() > 0) && cw_ready;
        push_m = in_valid && (q.size() < DEPTH);
        nw     = model_cw(in_data, inj_en, inj_pos);
        if (pop_m) begin
          void'(q.pop_front());
          mcnt = (mcnt + 1) % (1 << CNT_W);
        end
        if (push_m) q.push_back(nw);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic en,
                      input logic [3:0] pos);
    bit ok;
    ok = 1'b0;
    in_data  = d;
    inj_en   = en;
    inj_pos  = pos;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic inj_case(input logic en, input logic [3:0] pos,
                          input logic [11:0] lit);
    push(8'hA5, en, pos);
    cw_ready = 1'b1;
    @(negedge clk);
    chk("inj_head", cw_data, lit);
    chk("inj_decode", decode(cw_data), 8'hA5);
    step();
    cw_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_data = '0;
    in_valid = 1'b0;
    inj_en = 1'b0;
    inj_pos = '0;
    cw_ready = 1'b0;

    chk("model_00", model_cw(8'h00, 0, 0), 12'h000);
    chk("model_ff", model_cw(8'hFF, 0, 0), 12'hF77);
    chk("model_a5", model_cw(8'hA5, 0, 0), 12'hA27);
    chk("model_p5", model_cw(8'hA5, 1, 5), 12'hA37);
    chk("model_p12", model_cw(8'hA5, 1, 12), 12'h227);

    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", cw_valid, 0);
    step();

    // basic encode, one-cycle latency
    cw_ready = 1'b1;
    push(8'h00, 0, 0);
    @(negedge clk); chk("enc_00", cw_data, 12'h000); step();
    push(8'hFF, 0, 0);
    @(negedge clk); chk("enc_ff", cw_data, 12'hF77); step();
    push(8'hA5, 0, 0);
    @(negedge clk); chk("enc_a5", cw_data, 12'hA27); step();
    @(negedge clk);
    chk("count3", cw_count, 3);
    chk("empty3", cw_valid, 0);
    step();
    cw_ready = 1'b0;

    // injection
    inj_case(1, 4'd5,  12'hA37);
    inj_case(1, 4'd12, 12'h227);
    inj_case(1, 4'd0,  12'hA27);
    inj_case(1, 4'd14, 12'hA27);
    inj_case(0, 4'd5,  12'hA27);

    // fill past full
    for (int i = 0; i < DEPTH + 2; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h10 + 8'(i);
      inj_en   = 1'b0;
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_level", level, DEPTH);
    chk("full_ready", in_ready, 0);
    step();
    cw_ready = 1'b1;
    repeat (DEPTH + 2) step();
    @(negedge clk);
    chk("drained", level, 0);
    step();

    // steady stream at level 2
    cw_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h30 + 8'(i);
      step();
    end
    cw_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'h40 + 8'(i);
      @(negedge clk);
      chk("stream_level", level, 2);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();

    // mid-stream reset
    cw_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h60 + 8'(i);
      step();
    end
    rst = 1'b1;
    cw_ready = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mrst_valid", cw_valid, 0);
    chk("mrst_level", level, 0);
    chk("mrst_count", cw_count, 0);
    chk("mrst_ready", in_ready, 1);
    step();
    repeat (3) step();
    @(negedge clk);
    chk("mrst_no_old", cw_valid, 0);
    step();

    // random traffic
    for (int i = 0; i < 1000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      inj_en   = 1'($urandom_range(0, 1));
      inj_pos  = 4'($urandom_range(0, 15));
      cw_ready = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0;
    cw_ready = 1'b1;
    repeat (DEPTH + 2) step();

    // counter wrap after 2^CNT_W pops
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b1;
    inj_en = 1'b0;
    for (int i = 0; i < (1 << CNT_W); i++) begin
      in_data = 8'(i);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("wrap_count", cw_count, 0);
    chk("wrap_empty", cw_valid, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hamming12_encoder_tx.md
Name: hamming12_encoder_tx

Overview:
- Transmit-side Hamming(12,8) single-error-correcting encoder: the producer of the 12-bit codewords consumed by the team's Hamming decoder/corrector.
- Accepts bytes over a valid/ready handshake, computes the four parity bits, optionally flips one codeword bit for fault-injection testing, and buffers codewords in a small FIFO.
- Codewords leave the FIFO over a second valid/ready handshake.
- Also keeps a running count of delivered codewords.

Parameters:
DEPTH, 4, FIFO depth in codewords; power of two, 2..16
CNT_W, 16, width of delivered-codeword counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_data  input  8  byte to encode
in_valid  input  1  in_data/inj_* valid
in_ready  output  1  encoder can accept a byte this cycle
inj_en  input  1  flip one codeword bit for this byte
inj_pos  input  4  1-indexed bit position to flip (1..12)
cw_data  output  12  codeword at FIFO head
cw_valid  output  1  cw_data valid
cw_ready  input  1  downstream accepts codeword
level  output  $clog2(DEPTH)+1  FIFO occupancy
cw_count  output  CNT_W  codewords delivered since reset, wraps

Behaviour:
Codeword map (bit index 0..11 = positions 1..12, even parity):
- cw[11:8]=d[7:4]; cw[6:4]=d[3:1]; cw[2]=d[0].
- cw[0]=^{cw2,cw4,cw6,cw8,cw10}.
- cw[1]=^{cw2,cw5,cw6,cw9,cw10}.
- cw[3]=^{cw4,cw5,cw6,cw11}.
- cw[7]=^{cw8,cw9,cw10,cw11}.
- Result: an uncorrupted codeword has decoder syndrome 0.

Injection:
- Evaluated on the same cycle the byte is accepted.
- inj_en=1 and inj_pos in 1..12: store cw ^ (1<<(inj_pos-1)).
- inj_pos 0 or 13..15: no flip.
- inj_en=0: inj_pos ignored.

Handshakes:
- Push when in_valid&&in_ready.
- Pop when cw_valid&&cw_ready.
- in_ready = (level<DEPTH), purely from state, no combinational path from cw_ready.
- cw_valid = (level!=0).
- cw_data = FIFO head, driven combinationally from storage.
- Latency: byte accepted at edge N gives cw_valid=1 with its codeword after edge N; no same-cycle bypass.

Ordering and boundaries:
- Ordering is strictly FIFO; read and write pointers wrap modulo DEPTH.
- Simultaneous push and pop with 0<level<DEPTH: level unchanged, both take effect.
- Full: in_ready=0, so no push. A pop that cycle frees the slot for the next cycle only.
- Empty: cw_valid=0, cw_data holds the last storage value (don't-care to the bench). Pop is impossible.
- in_valid deasserted, or in_data changed, while in_ready=0: no effect.

Counter:
- cw_count increments by 1 on each pop; wraps 2^CNT_W-1 -> 0.

Reset (rst=1 at an edge, including mid-stream):
- Pointers=0, level=0, cw_count=0.
- Outputs after that edge: cw_valid=0, in_ready=1, level=0, cw_count=0.
- FIFO contents are discarded; storage need not be cleared.
- Handshakes presented during a reset cycle are ignored.

Decomposition:
- Shared package hamming12_pkg:
  - constants CW_W=12, DATA_W=8, parity position indices {0,1,3,7}.
  - pure function hamming12_encode(byte) -> 12-bit codeword.
- The decoder is refactored to use the same package map.
- One sub-module is natural: sync_fifo (WIDTH=12, DEPTH), holding pointers/level. The encoder top holds only encode, injection and the counter.

Test Plan:
- After reset, push 8'h00, 8'hFF, 8'hA5 with no injection, cw_ready=1 -> cw_data sequence 12'h000, 12'hF77, 12'hA27, each one cycle after acceptance; cw_count=3.
- Push 8'hA5 with inj_en=1: inj_pos=5 -> 12'hA37; inj_pos=12 -> 12'h227; inj_pos=0 or 14 -> 12'hA27. Looping each output through the decoder recovers 8'hA5.
- Hold cw_ready=0 and push DEPTH+2 bytes -> in_ready falls after DEPTH accepts, level=DEPTH. Release cw_ready -> outputs in order, none lost or duplicated.
- Push and pop every cycle at level=2 for 20 cycles -> level stays 2, order preserved across pointer wrap.
- Assert rst with level=3 mid-stream -> next cycle cw_valid=0, level=0, cw_count=0, in_ready=1. Old codewords are never emitted.
- Random 1000 bytes, random inj_en/inj_pos, random backpressure -> every output matches the scoreboard. After 2^CNT_W pops (CNT_W=4 override), cw_count wraps to 0.
